// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg
//   Shared constants for the Wishbone timer bank: register offsets inside a
//   channel window, the global PENDING offset, CTRL bit positions, the
//   default base address and the decoded register-select type.
package wb_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

  // Register offsets within one 16-byte channel window.
  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] LOAD_OFS   = 4'h4;
  localparam logic [3:0] COUNT_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;

  // Global register offset within the 512-byte block window.
  localparam logic [8:0] PENDING_OFS = 9'h100;

  // CTRL bit indices.
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_OUT_EN   = 3;
  localparam int CTRL_BITS     = 4;

endpackage

// File: rtl/wb_timer_channel.sv
// wb_timer_channel
//   One timer channel: CTRL, LOAD, COUNT, FLAG and the toggle output.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     freeze_i          bank-wide hold; no decrement and no expiry
//     ctrl_we_i         write strobe for CTRL (already decoded by the top)
//     load_we_i         write strobe for LOAD
//     status_we_i       write strobe for STATUS (write-1-to-clear FLAG)
//     wr_sel_i          Wishbone byte-lane enables of the current write
//     wr_dat_i          Wishbone write data
//     ctrl_o            CTRL register {OUT_EN, IE, PERIODIC, EN}
//     load_o, count_o   LOAD and COUNT registers
//     flag_o            expiry flag
//     tgl_o             toggles on every expiry
module wb_timer_channel
  import wb_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 freeze_i,
  input  logic                 ctrl_we_i,
  input  logic                 load_we_i,
  input  logic                 status_we_i,
  input  logic [3:0]           wr_sel_i,
  input  logic [31:0]          wr_dat_i,
  output logic [CTRL_BITS-1:0] ctrl_o,
  output logic [WIDTH-1:0]     load_o,
  output logic [WIDTH-1:0]     count_o,
  output logic                 flag_o,
  output logic                 tgl_o
);

  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     load_q, load_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 flag_q, flag_d;
  logic                 tgl_q, tgl_d;
  logic                 expire;
  logic                 arm;
  logic [31:0]          load_merged;

  always_comb begin
    expire = ctrl_q[CTRL_EN] & (count_q == '0) & ~freeze_i;

    // LOAD byte-lane merge over a 32-bit view; bits at and above WIDTH
    // are dropped when the merged word is written back.
    load_merged = 32'(load_q);
    for (int b = 0; b < 4; b++) begin
      if (wr_sel_i[b]) load_merged[8*b +: 8] = wr_dat_i[8*b +: 8];
    end
    load_d = load_we_i ? load_merged[WIDTH-1:0] : load_q;

    // All CTRL bits live in byte lane 0.
    ctrl_d = ctrl_q;
    if (ctrl_we_i && wr_sel_i[0]) ctrl_d = wr_dat_i[CTRL_BITS-1:0];
    arm = ~ctrl_q[CTRL_EN] & ctrl_d[CTRL_EN];
    // A one-shot expiry disables the channel even if CTRL is written
    // in the same cycle; mode follows the value in force this cycle.
    if (expire && !ctrl_q[CTRL_PERIODIC]) ctrl_d[CTRL_EN] = 1'b0;

    // Reload uses the LOAD value before any same-cycle LOAD write.
    count_d = count_q;
    if (arm) begin
      count_d = load_q;
    end else if (ctrl_q[CTRL_EN] && !freeze_i) begin
      if (count_q == '0) count_d = ctrl_q[CTRL_PERIODIC] ? load_q : '0;
      else               count_d = count_q - WIDTH'(1);
    end

    // Set beats a simultaneous write-1-to-clear.
    flag_d = flag_q;
    if (status_we_i && wr_sel_i[0] && wr_dat_i[0]) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;

    tgl_d = tgl_q ^ expire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      tgl_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      tgl_q   <= tgl_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign load_o  = load_q;
  assign count_o = count_q;
  assign flag_o  = flag_q;
  assign tgl_o   = tgl_q;

endmodule

// File: rtl/wb_timer_bank.sv
// wb_timer_bank
//   Wishbone-mapped bank of CHANNELS down-counting timers.
//   Ports:
//     wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//     wbs_cyc_i/stb_i/we_i     Wishbone classic cycle, strobe, write enable
//     wbs_sel_i, wbs_adr_i     byte lanes, byte address
//     wbs_dat_i / wbs_dat_o    write data / registered read data
//     wbs_ack_o                registered one-cycle acknowledge
//     la_data_in, la_oenb      bit 127 freezes the bank when its oenb is 0
//     la_data_out              packed COUNT values, channel 0 in the LSBs
//     io_out, io_oeb           per-channel toggle and active-low pad enable
//     irq                      irq[0] = OR of FLAG & IE; irq[2:1] = 0
//   Handshake: a request is accepted when cyc & stb hit the window while
//   ack is low; ack (and read data) is presented for exactly the next cycle
//   and write effects land on the same edge that raises ack.
module wb_timer_bank
  import wb_timer_pkg::*;
#(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [127:0]        la_data_in,
  input  logic [127:0]        la_oenb,
  output logic [127:0]        la_data_out,
  output logic [CHANNELS-1:0] io_out,
  output logic [CHANNELS-1:0] io_oeb,
  output logic [2:0]          irq
);

  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 hit, access, wr_stb, frozen;
  logic [8:0]           ofs;
  logic [3:0]           chan;
  logic [3:0]           reg_ofs;
  logic [31:0]          rdata;
  logic [255:0]         count_cat;
  logic                 unused_ok;

  logic [CTRL_BITS-1:0] ctrl_w  [CHANNELS];
  logic [WIDTH-1:0]     load_w  [CHANNELS];
  logic [WIDTH-1:0]     count_w [CHANNELS];
  logic [CHANNELS-1:0]  flag_w, tgl_w, ie_w, oen_w;

  assign ofs     = wbs_adr_i[8:0];
  assign chan    = ofs[7:4];
  assign reg_ofs = ofs[3:0];
  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
  assign access  = hit & ~ack_q;
  assign wr_stb  = access & wbs_we_i;
  assign frozen  = ~la_oenb[127] & la_data_in[127];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic sel_chan;
    assign sel_chan = wr_stb & ~ofs[8] & (chan == 4'(c));

    wb_timer_channel #(.WIDTH(WIDTH)) u_chan (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .freeze_i    (frozen),
      .ctrl_we_i   (sel_chan & (reg_ofs == CTRL_OFS)),
      .load_we_i   (sel_chan & (reg_ofs == LOAD_OFS)),
      .status_we_i (sel_chan & (reg_ofs == STATUS_OFS)),
      .wr_sel_i    (wbs_sel_i),
      .wr_dat_i    (wbs_dat_i),
      .ctrl_o      (ctrl_w[c]),
      .load_o      (load_w[c]),
      .count_o     (count_w[c]),
      .flag_o      (flag_w[c]),
      .tgl_o       (tgl_w[c])
    );

    assign ie_w[c]  = ctrl_w[c][CTRL_IE];
    assign oen_w[c] = ctrl_w[c][CTRL_OUT_EN];
  end

  // Read mux; unmapped offsets and absent channels read 0.
  always_comb begin
    rdata = '0;
    if (ofs == PENDING_OFS) begin
      rdata[CHANNELS-1:0] = flag_w;
    end else if (!ofs[8]) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (chan == 4'(c)) begin
          case (reg_ofs)
            CTRL_OFS:   rdata[CTRL_BITS-1:0] = ctrl_w[c];
            LOAD_OFS:   rdata[WIDTH-1:0]     = load_w[c];
            COUNT_OFS:  rdata[WIDTH-1:0]     = count_w[c];
            STATUS_OFS: rdata[0]             = flag_w[c];
            default:    rdata                = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    ack_d = access;
    dat_d = (access && !wbs_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  // Pack counts into a 256-bit scratch so 8 x 32 never overflows; only
  // the low 128 bits reach the LA.
  always_comb begin
    count_cat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      count_cat[c*WIDTH +: WIDTH] = count_w[c];
    end
  end

  assign la_data_out = count_cat[127:0];
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign io_out      = tgl_w;
  assign io_oeb      = ~oen_w;
  assign irq         = {2'b00, |(flag_w & ie_w)};

  assign unused_ok = ^{la_data_in[126:0], la_oenb[126:0], count_cat[255:128]};

endmodule
